// File: rtl/ca_pkg.sv
// ca_pkg: shared constants and FSM encoding for the CA display/update pipeline
package ca_pkg;
    localparam int ROWS   = 75;
    localparam int ADDR_W = 7;
    localparam int GEN_W  = 16;
    typedef logic [ADDR_W-1:0] row_t;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ROW_START = 2'd1;
    localparam logic [1:0] ROW_WAIT  = 2'd2;
    localparam logic [1:0] GEN_DONE  = 2'd3;
endpackage

// File: rtl/ca_gen_scheduler_if.sv
// ca_gen_scheduler_if: engine handshake and shared row-memory port bundle
interface ca_gen_scheduler_if;
    import ca_pkg::*;
    logic vga_req;
    row_t vga_addr;
    logic eng_mem_req;
    row_t eng_mem_addr;
    logic eng_done;
    logic eng_start;
    row_t eng_row;
    logic eng_gnt;
    logic vga_gnt;
    row_t mem_addr;
    modport slave (
        input  vga_req, vga_addr, eng_mem_req, eng_mem_addr, eng_done,
        output eng_start, eng_row, eng_gnt, vga_gnt, mem_addr
    );
    modport master (
        output vga_req, vga_addr, eng_mem_req, eng_mem_addr, eng_done,
        input  eng_start, eng_row, eng_gnt, vga_gnt, mem_addr
    );
endinterface

// File: rtl/ca_mem_arb.sv
// ca_mem_arb: fixed-priority row-memory read mux, display always wins
module ca_mem_arb
    import ca_pkg::*;
(
    input  logic vga_req_i,
    input  row_t vga_addr_i,
    input  logic eng_mem_req_i,
    input  row_t eng_mem_addr_i,
    output logic vga_gnt_o,
    output logic eng_gnt_o,
    output row_t mem_addr_o
);
    assign vga_gnt_o  = vga_req_i;
    assign eng_gnt_o  = eng_mem_req_i & ~vga_req_i;
    assign mem_addr_o = vga_req_i ? vga_addr_i : eng_mem_addr_i;
endmodule

// File: rtl/ca_gen_scheduler.sv
// ca_gen_scheduler: paces row-by-row generations and swaps buffers at vblank
module ca_gen_scheduler #(
    parameter int ROWS  = ca_pkg::ROWS,
    parameter int GEN_W = ca_pkg::GEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_rdy_i,
    input  logic              run_i,
    input  logic              step_i,
    input  logic [3:0]        gen_div_i,
    input  logic              vblank_start_i,
    ca_gen_scheduler_if.slave bus,
    output logic              buf_swap_o,
    output logic [GEN_W-1:0]  gen_count_o,
    output logic              busy_o,
    output logic              overrun_o
);
    import ca_pkg::*;

    logic [1:0]       state_q, state_d;
    row_t             eng_row_q, eng_row_d;
    logic [3:0]       frame_cnt_q, frame_cnt_d;
    logic             step_pend_q, step_pend_d;
    logic             eng_start_q, buf_swap_q, overrun_q;
    logic [GEN_W-1:0] gen_count_q;
    logic             vb_run, due, last_row, swap;

    ca_mem_arb u_arb (
        .vga_req_i      (bus.vga_req),
        .vga_addr_i     (bus.vga_addr),
        .eng_mem_req_i  (bus.eng_mem_req),
        .eng_mem_addr_i (bus.eng_mem_addr),
        .vga_gnt_o      (bus.vga_gnt),
        .eng_gnt_o      (bus.eng_gnt),
        .mem_addr_o     (bus.mem_addr)
    );

    assign vb_run   = init_rdy_i & run_i & vblank_start_i;
    assign due      = vb_run & (frame_cnt_q == gen_div_i);
    assign last_row = eng_row_q == ADDR_W'(ROWS - 1);
    assign swap     = (state_q == GEN_DONE) & vblank_start_i;
    assign busy_o   = state_q != IDLE;

    // frame divider: cleared when run drops, frozen while init_rdy is low
    assign frame_cnt_d = !run_i ? '0 : !vb_run ? frame_cnt_q : due ? '0 : frame_cnt_q + 4'd1;

    // generation sequencer: launch, walk the rows, then hold for the vblank swap
    always_comb begin
        state_d     = state_q;
        eng_row_d   = eng_row_q;
        step_pend_d = step_pend_q | (step_i & ~run_i & init_rdy_i);
        if (state_q == IDLE) begin
            if (init_rdy_i && (due || step_pend_q)) begin
                state_d     = ROW_START;
                eng_row_d   = '0;
                step_pend_d = 1'b0;
            end
        end else if (state_q == ROW_START) begin
            state_d = ROW_WAIT;
        end else if (state_q == ROW_WAIT) begin
            if (bus.eng_done) begin
                state_d   = last_row ? GEN_DONE : ROW_START;
                eng_row_d = last_row ? eng_row_q : eng_row_q + 1'b1;
            end
        end else if (vblank_start_i) begin
            state_d = IDLE;
        end
    end

    // state, pulses and counters; a dropped due generation latches overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            eng_row_q   <= '0;
            frame_cnt_q <= '0;
            step_pend_q <= 1'b0;
            eng_start_q <= 1'b0;
            buf_swap_q  <= 1'b0;
            gen_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            eng_row_q   <= eng_row_d;
            frame_cnt_q <= frame_cnt_d;
            step_pend_q <= step_pend_d;
            eng_start_q <= state_q == ROW_START;
            buf_swap_q  <= swap;
            gen_count_q <= gen_count_q + GEN_W'(swap);
            overrun_q   <= overrun_q | (due & busy_o);
        end
    end

    assign bus.eng_start = eng_start_q;
    assign bus.eng_row   = eng_row_q;
    assign buf_swap_o    = buf_swap_q;
    assign gen_count_o   = gen_count_q;
    assign overrun_o     = overrun_q;
endmodule
